// File: rtl/inst_fetch_queue.sv
// FWFT instruction queue between fetch and decode; push-to-head latency is one cycle, with no bypass.
// Backpressure: in_ready drops when full or flushing, and stall_req warns one entry early.
module inst_fetch_queue #(
  parameter int RWIDTH = 32,
  parameter int AWIDTH = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [RWIDTH-1:0]        in_data,
  input  logic [AWIDTH-1:0]        in_addr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RWIDTH-1:0]        out_data,
  output logic [AWIDTH-1:0]        out_addr,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_imm,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RWIDTH-1:0] mem_data [DEPTH];
  logic [AWIDTH-1:0] mem_addr [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CW'(DEPTH)) & ~flush;
  assign out_valid = (count != '0);
  assign stall_req = (count >= CW'(DEPTH - 1));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_addr   = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_opcode = out_data[31:26];
  assign out_rs     = out_data[25:21];
  assign out_rt     = out_data[20:16];
  assign out_rd     = out_data[15:11];
  assign out_imm    = {{16{out_data[15]}}, out_data[15:0]};

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small first-word-fall-through instruction queue between the instruction fetch block and the decode stage.
- Captures each fetched 32-bit instruction with its word address, and presents the oldest entry to decode with a valid/ready handshake.
- Pre-splits the head instruction into register/opcode fields.
- Raises an almost-full stall request so the PC can be held, and supports a single-cycle flush for branch redirects.

Parameters:
- RWIDTH, 32, instruction width in bits; field slicing assumes 32.
- AWIDTH, 6, instruction word-address width.
- DEPTH, 4, number of queue entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all queued entries (branch/jump redirect).
- in_valid  input  1  fetch side presents a valid instruction.
- in_data  input  RWIDTH  fetched instruction word.
- in_addr  input  AWIDTH  word address of in_data.
- in_ready  output  1  queue accepts in_data this cycle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_data  output  RWIDTH  head instruction.
- out_addr  output  AWIDTH  head address.
- out_opcode  output  6  out_data[31:26].
- out_rs  output  5  out_data[25:21].
- out_rt  output  5  out_data[20:16].
- out_rd  output  5  out_data[15:11].
- out_imm  output  32  out_data[15:0], sign-extended.
- stall_req  output  1  queue is almost full (count >= DEPTH-1).
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - DEPTH x (RWIDTH+AWIDTH) register array.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; both wrap modulo DEPTH naturally.
  - Occupancy register count, 0..DEPTH.
- Reset (rst=1 at clock edge): count=0, wr_ptr=0, rd_ptr=0. Array contents are not reset.
  - Outputs in the cycle after reset: out_valid=0, in_ready=1, stall_req=0, and all out_* data/field outputs 0.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH) & ~flush.
  - out_valid = (count != 0).
  - All handshake outputs are combinational from registered state and flush only; none depends on in_valid or out_ready.
- Push: at the clock edge, write {in_addr, in_data} to entry wr_ptr; wr_ptr++.
- Pop: rd_ptr++.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
  - Simultaneous push+pop is legal at any count from 1 to DEPTH-1.
- Full (count=DEPTH): in_ready=0, so no push.
  - A pop in the full cycle frees a slot; in_ready rises only in the following cycle. There is no same-cycle pass-through.
- Empty (count=0): out_valid=0.
  - A push becomes visible on out_valid in the next cycle, giving one-cycle latency from push to head.
  - No bypass of an empty queue.
- Head outputs:
  - out_data and out_addr read entry rd_ptr combinationally (first-word fall-through).
  - When out_valid=0, out_data, out_addr and all field outputs are forced to 0.
  - Field outputs are pure slices of out_data; out_imm = {{16{out_data[15]}}, out_data[15:0]}.
- Flush:
  - Priority order: rst > flush > push/pop.
  - flush=1 at an edge sets count=0, wr_ptr=0, rd_ptr=0. Any push or pop in that cycle is ignored (in_ready is already 0).
  - out_valid=0 from the next cycle.
  - A flush on an empty queue is a no-op.
  - Flush asserted for multiple cycles keeps the queue empty.
- stall_req = (count >= DEPTH-1), registered-state based.
  - Intended to hold the upstream PC one entry early; in_ready remains authoritative.
- Pointer wrap:
  - After DEPTH pushes, wr_ptr returns to 0.
  - Ordering is strictly FIFO across the wrap.
- Reset mid-operation: identical to flush, and additionally clears regardless of flush.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, stall_req=0, out_data=0, out_imm=0.
- Single push of in_data=32'h8C22FFFC, in_addr=6'd5; hold out_ready=0 -> next cycle out_valid=1, out_addr=5, out_opcode=6'h23, out_rs=1, out_rt=2, out_imm=32'hFFFFFFFC, count=1.
- Push 4 words (A0..A3, addr 0..3) with out_ready=0:
  - After 3 pushes, stall_req=1.
  - After 4 pushes, in_ready=0 and count=4.
  - A fifth in_valid is not accepted.
  - Draining with out_ready=1 yields A0, A1, A2, A3 in order, then out_valid=0.
- Continuous streaming, in_valid=1 and out_ready=1 for 10 cycles, addrs 0..9 -> count stays 1 after the first cycle; outputs appear in order 0..9 with one-cycle latency, including across the pointer wrap.
- With count=3, assert flush while in_valid=1 and out_ready=1 -> in_ready=0 in that cycle; next cycle count=0 and out_valid=0; a following push of addr 6'd40 is the next head.
- Queue full with count=4, then rst=1 for one cycle while in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and nothing from the reset cycle was stored.
